// File: rtl/redbus_pkg.sv
// Shared Redbus definitions: bus widths, strobe-length default and master FSM encoding.
package redbus_pkg;

  localparam int REDBUS_ADDR_W            = 16;
  localparam int REDBUS_DATA_W            = 8;
  localparam int REDBUS_STROBE_CYCLES_DEF = 2;
  localparam int REDBUS_CNT_W             = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

endpackage

// File: rtl/redbus_master.sv
// Redbus master: turns one core request into a SETUP / STROBE / HOLD bus cycle
// with registered strobes, address, enable and data-output enable.
//
// state  | meaning
// IDLE   | ready for a request, bus released (Enable=0, Data high-Z)
// SETUP  | address/enable (and write data) presented, strobes low
// STROBE | read or write strobe high for STROBE_CYCLES cycles
// HOLD   | strobe low, bus still held, RspValid pulse
module redbus_master
  import redbus_pkg::*;
#(
  parameter int STROBE_CYCLES = REDBUS_STROBE_CYCLES_DEF
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     ReqValid,
  output logic                     ReqReady,
  input  logic                     ReqWrite,
  input  logic [REDBUS_ADDR_W-1:0] ReqAddress,
  input  logic [REDBUS_DATA_W-1:0] ReqWData,
  output logic                     RspValid,
  output logic [REDBUS_DATA_W-1:0] RspRData,
  output logic [REDBUS_ADDR_W-1:0] Address,
  inout  wire  [REDBUS_DATA_W-1:0] Data,
  output logic                     ReadRedbus,
  output logic                     WriteRedbus,
  output logic                     Enable
);

  localparam logic [REDBUS_CNT_W-1:0] LP_CNT_LOAD = REDBUS_CNT_W'(STROBE_CYCLES - 1);

  state_t                    r_state;
  state_t                    w_next_state;
  logic [REDBUS_CNT_W-1:0]   r_cnt;
  logic [REDBUS_CNT_W-1:0]   w_cnt_nxt;
  logic                      r_write;
  logic [REDBUS_DATA_W-1:0]  r_wdata;
  logic                      r_data_oe;
  logic                      w_accept;
  logic                      w_write_nxt;
  logic                      w_last_strobe;

  assign w_accept      = (r_state == ST_IDLE) && ReqValid;
  assign w_write_nxt   = w_accept ? ReqWrite : r_write;
  assign w_last_strobe = (r_state == ST_STROBE) && (r_cnt == '0);

  assign Data = r_data_oe ? r_wdata : {REDBUS_DATA_W{1'bz}};

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_cnt_nxt    = r_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (ReqValid) w_next_state = ST_SETUP;
      end
      ST_SETUP: begin
        w_next_state = ST_STROBE;
        w_cnt_nxt    = LP_CNT_LOAD;
      end
      ST_STROBE: begin
        if (r_cnt == '0) w_next_state = ST_HOLD;
        else             w_cnt_nxt    = r_cnt - 1'b1;
      end
      ST_HOLD: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up
  // exactly with r_state while staying glitch-free on the bus.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ReqReady    <= 1'b1;
      Enable      <= 1'b0;
      ReadRedbus  <= 1'b0;
      WriteRedbus <= 1'b0;
      RspValid    <= 1'b0;
      r_data_oe   <= 1'b0;
      Address     <= '0;
      RspRData    <= '0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
    end else begin
      ReqReady    <= (w_next_state == ST_IDLE);
      Enable      <= (w_next_state != ST_IDLE);
      ReadRedbus  <= (w_next_state == ST_STROBE) && !w_write_nxt;
      WriteRedbus <= (w_next_state == ST_STROBE) && w_write_nxt;
      RspValid    <= (w_next_state == ST_HOLD);
      r_data_oe   <= (w_next_state != ST_IDLE) && w_write_nxt;
      if (w_accept) begin
        Address <= ReqAddress;
        r_write <= ReqWrite;
        r_wdata <= ReqWData;
      end
      if (w_last_strobe && !r_write) RspRData <= Data;
    end
  end

endmodule

// File: tb/tb_redbus_master.sv
// Directed bench for redbus_master: one DUT with the default strobe length and
// one with a single-cycle strobe, each with a simple Redbus responder.
module tb_redbus_master;

  logic        Clock;
  logic        Reset;

  logic        req_valid0, req_write0;
  logic [15:0] req_addr0;
  logic [7:0]  req_wdata0;
  logic        req_ready0, rsp_valid0, rd0, wr0, en0;
  logic [7:0]  rsp_rdata0;
  logic [15:0] addr0;
  wire  [7:0]  data0;
  logic [7:0]  rsp_val0;

  logic        req_valid1, req_write1;
  logic [15:0] req_addr1;
  logic [7:0]  req_wdata1;
  logic        req_ready1, rsp_valid1, rd1, wr1, en1;
  logic [7:0]  rsp_rdata1;
  logic [15:0] addr1;
  wire  [7:0]  data1;
  logic [7:0]  rsp_val1;

  int errors = 0;
  int checks = 0;
  logic [23:0] wr_log[$];

  redbus_master #(.STROBE_CYCLES(2)) dut0 (
    .Clock(Clock), .Reset(Reset),
    .ReqValid(req_valid0), .ReqReady(req_ready0), .ReqWrite(req_write0),
    .ReqAddress(req_addr0), .ReqWData(req_wdata0),
    .RspValid(rsp_valid0), .RspRData(rsp_rdata0),
    .Address(addr0), .Data(data0),
    .ReadRedbus(rd0), .WriteRedbus(wr0), .Enable(en0)
  );

  redbus_master #(.STROBE_CYCLES(1)) dut1 (
    .Clock(Clock), .Reset(Reset),
    .ReqValid(req_valid1), .ReqReady(req_ready1), .ReqWrite(req_write1),
    .ReqAddress(req_addr1), .ReqWData(req_wdata1),
    .RspValid(rsp_valid1), .RspRData(rsp_rdata1),
    .Address(addr1), .Data(data1),
    .ReadRedbus(rd1), .WriteRedbus(wr1), .Enable(en1)
  );

  // Responders: drive read data only while selected and strobed.
  assign data0 = (en0 && rd0) ? rsp_val0 : 8'hzz;
  assign data1 = (en1 && rd1) ? rsp_val1 : 8'hzz;

  always @(posedge wr0) wr_log.push_back({addr0, data0});

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Vector layout: {Enable, WriteRedbus, ReadRedbus, RspValid, ReqReady, Address, Data, RspRData}
  task automatic test_reset();
    logic [36:0] got, exp;
    repeat (2) @(posedge Clock);
    #1;
    got = {en0, wr0, rd0, rsp_valid0, req_ready0, addr0, data0, rsp_rdata0};
    exp = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 8'hzz, 8'h00};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_asserted: got %h exp %h", got, exp);
    end
    Reset = 1'b0;
    @(posedge Clock); #1;
    got = {en0, wr0, rd0, rsp_valid0, req_ready0, addr0, data0, rsp_rdata0};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_released: got %h exp %h", got, exp);
    end
  endtask

  task automatic test_write();
    logic [36:0] got, exp;
    wr_log.delete();
    req_valid0 = 1'b1; req_write0 = 1'b1; req_addr0 = 16'h0002; req_wdata0 = 8'hA5;
    @(posedge Clock); #1;
    req_valid0 = 1'b0; req_write0 = 1'b0; req_addr0 = 16'hFFFF; req_wdata0 = 8'h00;
    for (int c = 1; c <= 5; c++) begin
      exp = {c <= 4, c == 2 || c == 3, 1'b0, c == 4, c == 5, 16'h0002,
             (c <= 4) ? 8'hA5 : 8'hzz, 8'h00};
      got = {en0, wr0, rd0, rsp_valid0, req_ready0, addr0, data0, rsp_rdata0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL write cycle %0d: got %h exp %h", c, got, exp);
      end
      @(posedge Clock); #1;
    end
    checks++;
    if (wr_log.size() != 1 || wr_log[0] !== 24'h0002A5) begin
      errors++;
      $display("FAIL write_responder: got %0d entries first %h exp 1 entry 0002a5",
               wr_log.size(), (wr_log.size() > 0) ? wr_log[0] : 24'h0);
    end
  endtask

  task automatic test_read();
    logic [36:0] got, exp;
    rsp_val0 = 8'h3C;
    req_valid0 = 1'b1; req_write0 = 1'b0; req_addr0 = 16'h0000; req_wdata0 = 8'h99;
    @(posedge Clock); #1;
    req_valid0 = 1'b0; req_write0 = 1'b1; req_addr0 = 16'h1234; req_wdata0 = 8'h11;
    for (int c = 1; c <= 5; c++) begin
      exp = {c <= 4, 1'b0, c == 2 || c == 3, c == 4, c == 5, 16'h0000,
             (c == 2 || c == 3) ? 8'h3C : 8'hzz, (c >= 4) ? 8'h3C : 8'h00};
      got = {en0, wr0, rd0, rsp_valid0, req_ready0, addr0, data0, rsp_rdata0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL read cycle %0d: got %h exp %h", c, got, exp);
      end
      @(posedge Clock); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] got, exp;
    logic       txn_wr;
    int         ph;
    wr_log.delete();
    rsp_val0 = 8'h6E;
    for (int k = 0; k < 15; k++) begin
      ph     = k % 5;
      txn_wr = ((k / 5) % 2) == 0;
      exp = {ph == 0, ph == 4, ph != 0,
             (ph == 2 || ph == 3) && txn_wr, (ph == 2 || ph == 3) && !txn_wr};
      got = {req_ready0, rsp_valid0, en0, wr0, rd0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: got %b exp %b", k, got, exp);
      end
      req_valid0 = 1'b1;
      req_write0 = ~k[0];
      req_addr0  = 16'h1000 + 16'(k);
      req_wdata0 = 8'h10 + 8'(k);
      @(posedge Clock); #1;
    end
    req_valid0 = 1'b0;
    checks++;
    if (wr_log.size() != 2 || wr_log[0] !== 24'h100010 || wr_log[1] !== 24'h100A1A) begin
      errors++;
      $display("FAIL back_to_back_log: got %0d entries exp 2 (100010, 100a1a)", wr_log.size());
    end
    checks++;
    if (rsp_rdata0 !== 8'h6E) begin
      errors++;
      $display("FAIL back_to_back_rdata: got %h exp 6e", rsp_rdata0);
    end
  endtask

  task automatic test_reset_abort();
    logic [36:0] got, exp;
    rsp_val0 = 8'h77;
    req_valid0 = 1'b1; req_write0 = 1'b0; req_addr0 = 16'h0010;
    @(posedge Clock); #1;
    req_valid0 = 1'b0;
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    checks++;
    if ({en0, rd0, wr0} !== 3'b110) begin
      errors++;
      $display("FAIL abort_strobe2: got %b exp 110", {en0, rd0, wr0});
    end
    Reset = 1'b1;
    #1;
    got = {en0, wr0, rd0, rsp_valid0, req_ready0, addr0, data0, rsp_rdata0};
    exp = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 8'hzz, 8'h00};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL abort_reset: got %h exp %h", got, exp);
    end
    #2;
    Reset = 1'b0;
    req_valid0 = 1'b1; req_write0 = 1'b1; req_addr0 = 16'h0020; req_wdata0 = 8'h5A;
    @(posedge Clock); #1;
    req_valid0 = 1'b0; req_write0 = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      exp = {c <= 4, c == 2 || c == 3, 1'b0, c == 4, c == 5, 16'h0020,
             (c <= 4) ? 8'h5A : 8'hzz, 8'h00};
      got = {en0, wr0, rd0, rsp_valid0, req_ready0, addr0, data0, rsp_rdata0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL abort_next_write cycle %0d: got %h exp %h", c, got, exp);
      end
      @(posedge Clock); #1;
    end
  endtask

  task automatic test_strobe1();
    logic [36:0] got, exp;
    rsp_val1 = 8'hFF;
    req_valid1 = 1'b1; req_write1 = 1'b0; req_addr1 = 16'h0001; req_wdata1 = 8'h00;
    @(posedge Clock); #1;
    req_valid1 = 1'b0; req_addr1 = 16'h0000;
    for (int c = 1; c <= 4; c++) begin
      exp = {c <= 3, 1'b0, c == 2, c == 3, c == 4, 16'h0001,
             (c == 2) ? 8'hFF : 8'hzz, (c >= 3) ? 8'hFF : 8'h00};
      got = {en1, wr1, rd1, rsp_valid1, req_ready1, addr1, data1, rsp_rdata1};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL strobe1 cycle %0d: got %h exp %h", c, got, exp);
      end
      @(posedge Clock); #1;
    end
  endtask

  initial begin
    Reset = 1'b1;
    req_valid0 = 1'b0; req_write0 = 1'b0; req_addr0 = '0; req_wdata0 = '0; rsp_val0 = '0;
    req_valid1 = 1'b0; req_write1 = 1'b0; req_addr1 = '0; req_wdata1 = '0; rsp_val1 = '0;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_reset_abort();
    test_strobe1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
